// File: rtl/vector_cache_pkg.sv
// vector_cache_pkg: shared request/RDB types, widths and helpers for the data-ram read path.
package vector_cache_pkg;
    localparam int RW_DB_ENTRY_NUM      = 16;
    localparam int DB_ENTRY_IDX_WIDTH   = 4;
    localparam int MSHR_ENTRY_IDX_WIDTH = 4;
    localparam int TXNID_WIDTH          = 6;
    localparam int CH_IDX_MAX_W         = 3;

    typedef struct packed {
        logic [DB_ENTRY_IDX_WIDTH-1:0]   db_entry_id;
        logic [TXNID_WIDTH-1:0]          txnid;
        logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob_entry_id;
    } arb_out_req_t;

    typedef struct packed {
        logic [DB_ENTRY_IDX_WIDTH-1:0] db_entry_id;
        logic [TXNID_WIDTH-1:0]        txnid;
    } read_rdb_addr_t;

    typedef struct packed {
        arb_out_req_t            pld;
        logic [CH_IDX_MAX_W-1:0] ch;
    } rdb_q_entry_t;

    function automatic int ch_idx_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rdb_agent_mc_if.sv
// rdb_agent_mc_if: request, RDB port, upstream release and entry-allocation signals of the agent.
interface rdb_agent_mc_if import vector_cache_pkg::*; #(parameter int CH_NUM = 2);
    localparam int CH_IDX_W = ch_idx_w(CH_NUM);
    logic [CH_NUM-1:0]               dataram_rd_vld;
    arb_out_req_t [CH_NUM-1:0]       dataram_rd_pld;
    logic [CH_NUM-1:0]               dataram_rd_rdy;
    logic                            us_rdy;
    logic                            rdb_mem_en;
    logic                            rdb_wr_en;
    read_rdb_addr_t                  rdb_addr;
    logic [CH_IDX_W-1:0]             rdb_rd_ch;
    logic                            to_us_done;
    logic [MSHR_ENTRY_IDX_WIDTH-1:0] to_us_done_idx;
    logic [CH_IDX_W-1:0]             to_us_done_ch;
    logic                            alloc_vld;
    logic [DB_ENTRY_IDX_WIDTH-1:0]   alloc_idx;
    logic                            alloc_rdy;
    logic                            err;

    modport master (
        output dataram_rd_vld, dataram_rd_pld, us_rdy, alloc_rdy,
        input  dataram_rd_rdy, rdb_mem_en, rdb_wr_en, rdb_addr, rdb_rd_ch,
               to_us_done, to_us_done_idx, to_us_done_ch, alloc_vld, alloc_idx, err
    );
    modport slave (
        input  dataram_rd_vld, dataram_rd_pld, us_rdy, alloc_rdy,
        output dataram_rd_rdy, rdb_mem_en, rdb_wr_en, rdb_addr, rdb_rd_ch,
               to_us_done, to_us_done_idx, to_us_done_ch, alloc_vld, alloc_idx, err
    );
endinterface

// File: rtl/rdb_rd_queue.sv
// rdb_rd_queue: synchronous FIFO of pending RDB reads; depth must be a power of 2.
module rdb_rd_queue import vector_cache_pkg::*; #(
    parameter int  DEPTH = 4,
    parameter type T     = rdb_q_entry_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  T                           din,
    input  logic                       pop,
    output T                           dout,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    T mem [DEPTH];
    logic [AW-1:0] wp, rp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) if (push) mem[wp] <= din;

    assign dout  = mem[rp];
    assign empty = count == '0;
endmodule

// File: rtl/rdb_agent_mc.sv
// rdb_agent_mc: multi-channel RDB agent - RR accept with credits, delayed RDB write, queued read, ROB release.
// Optional protocol checker on err enabled by defining RDB_AGENT_MC_ERR_CHK_EN.
module rdb_agent_mc import vector_cache_pkg::*; #(
    parameter int CH_NUM      = 2,
    parameter int ENTRY_NUM   = RW_DB_ENTRY_NUM,
    parameter int RD_SRAM_DLY = 2,
    parameter int RD_Q_DEPTH  = 4,
    parameter int DONE_DLY    = 2
) (
    input logic           clk,
    input logic           rst_n,
    rdb_agent_mc_if.slave bus
);
    localparam int CH_IDX_W = ch_idx_w(CH_NUM);
    localparam int CW       = $clog2(RD_Q_DEPTH+1);

    typedef struct packed {
        arb_out_req_t        pld;
        logic [CH_IDX_W-1:0] ch;
    } q_ent_t;

    logic [CH_IDX_W-1:0]             ptr, win;
    logic                            found, acc, wr, pop, q_empty;
    logic [CW-1:0]                   q_count;
    logic [RD_SRAM_DLY-1:0]          wr_vld;
    q_ent_t                          wr_pipe [RD_SRAM_DLY];
    q_ent_t                          q_head;
    arb_out_req_t                    addr_src;
    logic [DONE_DLY-1:0]             done_vld;
    logic [MSHR_ENTRY_IDX_WIDTH-1:0] done_rob [DONE_DLY];
    logic [CH_IDX_W-1:0]             done_ch [DONE_DLY];
    logic [ENTRY_NUM-1:0]            free_map, alloc_mask, free_mask;

    always_comb begin
        win   = ptr;
        found = 1'b0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (bus.dataram_rd_vld[CH_IDX_W'((int'(ptr) + i) % CH_NUM)]) begin
                win   = CH_IDX_W'((int'(ptr) + i) % CH_NUM);
                found = 1'b1;
            end
        end
    end

    // Credits cover requests in the SRAM pipeline plus those parked in the queue.
    assign acc = found && (int'($countones(wr_vld)) + int'(q_count) < RD_Q_DEPTH);
    assign bus.dataram_rd_rdy = acc ? CH_NUM'(1) << win : '0;

    assign wr  = wr_vld[RD_SRAM_DLY-1];
    assign pop = !q_empty && bus.us_rdy && !wr;

    assign addr_src       = wr ? wr_pipe[RD_SRAM_DLY-1].pld : q_head.pld;
    assign bus.rdb_mem_en = wr | pop;
    assign bus.rdb_wr_en  = wr;
    assign bus.rdb_addr   = (wr | pop) ? {addr_src.db_entry_id, addr_src.txnid} : '0;
    assign bus.rdb_rd_ch  = pop ? q_head.ch : '0;

    assign bus.to_us_done     = done_vld[DONE_DLY-1];
    assign bus.to_us_done_idx = done_vld[DONE_DLY-1] ? done_rob[DONE_DLY-1] : '0;
    assign bus.to_us_done_ch  = done_vld[DONE_DLY-1] ? done_ch[DONE_DLY-1] : '0;

    always_comb begin
        bus.alloc_idx = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) if (free_map[i]) bus.alloc_idx = DB_ENTRY_IDX_WIDTH'(i);
    end
    assign bus.alloc_vld = |free_map;
    assign alloc_mask    = (bus.alloc_vld && bus.alloc_rdy) ? ENTRY_NUM'(1) << bus.alloc_idx : '0;
    assign free_mask     = pop ? ENTRY_NUM'(1) << q_head.pld.db_entry_id : '0;

    rdb_rd_queue #(.DEPTH(RD_Q_DEPTH), .T(q_ent_t)) u_rd_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr),
        .din   (wr_pipe[RD_SRAM_DLY-1]),
        .pop   (pop),
        .dout  (q_head),
        .empty (q_empty),
        .count (q_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            wr_vld   <= '0;
            done_vld <= '0;
            free_map <= '1;
            for (int i = 0; i < RD_SRAM_DLY; i++) wr_pipe[i] <= '0;
            for (int i = 0; i < DONE_DLY; i++) begin
                done_rob[i] <= '0;
                done_ch[i]  <= '0;
            end
        end else begin
            if (acc) ptr <= CH_IDX_W'((int'(win) + 1) % CH_NUM);
            wr_vld     <= RD_SRAM_DLY'({wr_vld, acc});
            wr_pipe[0] <= '{pld: bus.dataram_rd_pld[win], ch: win};
            for (int i = 1; i < RD_SRAM_DLY; i++) wr_pipe[i] <= wr_pipe[i-1];
            done_vld    <= DONE_DLY'({done_vld, pop});
            done_rob[0] <= q_head.pld.rob_entry_id;
            done_ch[0]  <= q_head.ch;
            for (int i = 1; i < DONE_DLY; i++) begin
                done_rob[i] <= done_rob[i-1];
                done_ch[i]  <= done_ch[i-1];
            end
            free_map <= (free_map & ~alloc_mask) | free_mask;
        end
    end

`ifdef RDB_AGENT_MC_ERR_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.err <= 1'b0;
        else if ((wr && free_map[wr_pipe[RD_SRAM_DLY-1].pld.db_entry_id]) ||
                 (bus.alloc_rdy && !bus.alloc_vld) ||
                 (pop && free_map[q_head.pld.db_entry_id])) bus.err <= 1'b1;
    end
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_rdb_agent_mc.sv
// tb_rdb_agent_mc: vector table, directed corner sequences and random traffic against a timestamped queue model.
module tb_rdb_agent_mc;
    import vector_cache_pkg::*;

    localparam int D  = 2;
    localparam int QD = 4;
    localparam int DD = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rdb_agent_mc_if #(.CH_NUM(2)) bus ();

    rdb_agent_mc #(
        .CH_NUM(2), .ENTRY_NUM(16), .RD_SRAM_DLY(D), .RD_Q_DEPTH(QD), .DONE_DLY(DD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int           t;
        arb_out_req_t pld;
        int           ch;
    } ev_t;

    typedef struct {
        logic [1:0] vld;
        logic [3:0] db;
        logic [3:0] rob;
        logic       us;
        logic       ar;
        logic [1:0] e_rdy;
        logic       e_men;
        logic       e_wen;
        logic [3:0] e_db;
        logic       e_done;
        logic [3:0] e_didx;
        logic [3:0] e_aidx;
    } vec_t;

    ev_t         infl[$], rq[$], dq[$];
    logic [15:0] free_m;
    int          ptr, cyc, checks, failures;
    logic [1:0]  s_rdy;
    logic        s_men, s_wen, s_done, s_avld, s_err;
    logic [3:0]  s_db, s_aidx, s_didx;
    vec_t        tv [10];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", n, cyc, a, e);
        end
    endtask

    task automatic set_pld(input int ch, input logic [3:0] db, input logic [5:0] txn, input logic [3:0] rob);
        bus.dataram_rd_pld[ch] = '{db_entry_id: db, txnid: txn, rob_entry_id: rob};
    endtask

    task automatic drive(input logic [1:0] v, input logic us, input logic ar);
        bus.dataram_rd_vld = v;
        bus.us_rdy         = us;
        bus.alloc_rdy      = ar;
    endtask

    // One clock: compare DUT against the model mid-cycle, then advance the model past the edge.
    task automatic step();
        int cred, w, aidx;
        logic [1:0] er;
        logic wr, pop, dn, avld;
        ev_t h;
        @(negedge clk);
        cred = infl.size() + rq.size();
        w = -1;
        if (cred < QD)
            for (int i = 0; i < 2; i++)
                if (w < 0 && bus.dataram_rd_vld[(ptr + i) % 2]) w = (ptr + i) % 2;
        er   = (w >= 0) ? 2'(1 << w) : 2'b00;
        wr   = infl.size() > 0 && infl[0].t == cyc;
        pop  = rq.size() > 0 && bus.us_rdy && !wr;
        dn   = dq.size() > 0 && dq[0].t == cyc;
        avld = |free_m;
        aidx = 0;
        for (int i = 15; i >= 0; i--) if (free_m[i]) aidx = i;
        s_rdy  = bus.dataram_rd_rdy;
        s_men  = bus.rdb_mem_en;
        s_wen  = bus.rdb_wr_en;
        s_db   = bus.rdb_addr.db_entry_id;
        s_done = bus.to_us_done;
        s_didx = bus.to_us_done_idx;
        s_avld = bus.alloc_vld;
        s_aidx = bus.alloc_idx;
        s_err  = bus.err;
        chk("rdy", 32'(bus.dataram_rd_rdy), 32'(er));
        chk("mem_en", 32'(bus.rdb_mem_en), 32'(wr | pop));
        chk("wr_en", 32'(bus.rdb_wr_en), 32'(wr));
        if (wr) chk("wr_addr", 32'(bus.rdb_addr), 32'({infl[0].pld.db_entry_id, infl[0].pld.txnid}));
        if (pop) begin
            chk("rd_addr", 32'(bus.rdb_addr), 32'({rq[0].pld.db_entry_id, rq[0].pld.txnid}));
            chk("rd_ch", 32'(bus.rdb_rd_ch), 32'(rq[0].ch));
        end
        chk("done", 32'(bus.to_us_done), 32'(dn));
        if (dn) begin
            chk("done_idx", 32'(bus.to_us_done_idx), 32'(dq[0].pld.rob_entry_id));
            chk("done_ch", 32'(bus.to_us_done_ch), 32'(dq[0].ch));
        end
        chk("alloc_vld", 32'(bus.alloc_vld), 32'(avld));
        if (avld) chk("alloc_idx", 32'(bus.alloc_idx), 32'(aidx));
`ifndef RDB_AGENT_MC_ERR_CHK_EN
        chk("err", 32'(bus.err), 32'(0));
`endif
        if (avld && bus.alloc_rdy) free_m[aidx] = 1'b0;
        if (dn) void'(dq.pop_front());
        if (pop) begin
            h = rq.pop_front();
            free_m[h.pld.db_entry_id] = 1'b1;
            h.t = cyc + DD;
            dq.push_back(h);
        end
        if (wr) rq.push_back(infl.pop_front());
        if (w >= 0) begin
            infl.push_back('{t: cyc + D, pld: bus.dataram_rd_pld[w], ch: w});
            ptr = (w + 1) % 2;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(2'b00, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_rdy", 32'(bus.dataram_rd_rdy), 32'(0));
        chk("rst_mem_en", 32'(bus.rdb_mem_en), 32'(0));
        chk("rst_wr_en", 32'(bus.rdb_wr_en), 32'(0));
        chk("rst_addr", 32'(bus.rdb_addr), 32'(0));
        chk("rst_done", 32'(bus.to_us_done), 32'(0));
        chk("rst_done_idx", 32'(bus.to_us_done_idx), 32'(0));
        chk("rst_alloc_vld", 32'(bus.alloc_vld), 32'(1));
        chk("rst_alloc_idx", 32'(bus.alloc_idx), 32'(0));
        chk("rst_err", 32'(bus.err), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        infl.delete();
        rq.delete();
        dq.delete();
        free_m = '1;
        ptr = 0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        drive(2'b00, 1'b0, 1'b0);
        set_pld(0, 4'd0, 6'd0, 4'd0);
        set_pld(1, 4'd0, 6'd1, 4'd0);

        // Single request after allocating 0..3: write T+2, read T+3, entry 3 free T+4, done T+5.
        tv[0] = '{2'b00, 4'd0, 4'd0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0};
        tv[1] = '{2'b00, 4'd0, 4'd0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1};
        tv[2] = '{2'b00, 4'd0, 4'd0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2};
        tv[3] = '{2'b00, 4'd0, 4'd0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3};
        tv[4] = '{2'b01, 4'd3, 4'd5, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4};
        tv[5] = '{2'b00, 4'd3, 4'd5, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4};
        tv[6] = '{2'b00, 4'd3, 4'd5, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 4'd4};
        tv[7] = '{2'b00, 4'd3, 4'd5, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 4'd3, 1'b0, 4'd0, 4'd4};
        tv[8] = '{2'b00, 4'd3, 4'd5, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3};
        tv[9] = '{2'b00, 4'd3, 4'd5, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 4'd3};

        do_reset();
        for (int k = 0; k < 10; k++) begin
            set_pld(0, tv[k].db, 6'd0, tv[k].rob);
            drive(tv[k].vld, tv[k].us, tv[k].ar);
            step();
            chk("tv_rdy", 32'(s_rdy), 32'(tv[k].e_rdy));
            chk("tv_mem_en", 32'(s_men), 32'(tv[k].e_men));
            chk("tv_wr_en", 32'(s_wen), 32'(tv[k].e_wen));
            if (tv[k].e_men) chk("tv_db", 32'(s_db), 32'(tv[k].e_db));
            chk("tv_done", 32'(s_done), 32'(tv[k].e_done));
            if (tv[k].e_done) chk("tv_done_idx", 32'(s_didx), 32'(tv[k].e_didx));
            chk("tv_alloc_idx", 32'(s_aidx), 32'(tv[k].e_aidx));
        end

        // Both channels pending, upstream stalled: alternating grants then credit stop at 4.
        do_reset();
        set_pld(0, 4'd1, 6'd0, 4'd1);
        set_pld(1, 4'd2, 6'd1, 4'd2);
        drive(2'b11, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk(k < 4 ? "alt_rdy" : "full_rdy", 32'(s_rdy), k < 4 ? ((k % 2 == 0) ? 32'd1 : 32'd2) : 32'd0);
        end
        drive(2'b00, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("drain_rd", 32'({s_men, s_wen}), 32'(2'b10));
        end
        step();
        chk("drained_idle", 32'(s_men), 32'(0));
        drive(2'b01, 1'b0, 1'b0);
        step();
        chk("resume_rdy", 32'(s_rdy), 32'(1));
        drive(2'b00, 1'b1, 1'b0);
        repeat (8) step();

        // Pop while full frees a credit for the very next cycle.
        do_reset();
        drive(2'b11, 1'b0, 1'b0);
        repeat (10) step();
        drive(2'b11, 1'b1, 1'b0);
        step();
        chk("full_pop_rdy", 32'(s_rdy), 32'(0));
        chk("full_pop_rd", 32'({s_men, s_wen}), 32'(2'b10));
        step();
        chk("acc_after_pop", 32'(s_rdy), 32'(1));
        drive(2'b00, 1'b1, 1'b0);
        repeat (12) step();

        // Write and pending read in the same cycle: write wins, read follows.
        do_reset();
        set_pld(0, 4'd10, 6'd3, 4'd1);
        drive(2'b01, 1'b0, 1'b0);
        step();
        set_pld(0, 4'd11, 6'd4, 4'd2);
        step();
        drive(2'b00, 1'b0, 1'b0);
        step();
        drive(2'b00, 1'b1, 1'b0);
        step();
        chk("coll_wr", 32'({s_men, s_wen, s_db}), 32'({2'b11, 4'd11}));
        step();
        chk("coll_rd0", 32'({s_men, s_wen, s_db}), 32'({2'b10, 4'd10}));
        step();
        chk("coll_rd1", 32'({s_men, s_wen, s_db}), 32'({2'b10, 4'd11}));
        repeat (4) step();

        // Allocate every entry, then free entry 7 through a read.
        do_reset();
        drive(2'b00, 1'b0, 1'b1);
        repeat (16) step();
        drive(2'b00, 1'b0, 1'b0);
        step();
        chk("all_busy", 32'(s_avld), 32'(0));
        set_pld(0, 4'd7, 6'd5, 4'd9);
        drive(2'b01, 1'b1, 1'b0);
        step();
        drive(2'b00, 1'b1, 1'b0);
        step();
        step();
        step();
        chk("pop7_still_busy", 32'(s_avld), 32'(0));
        step();
        chk("free7_vld", 32'(s_avld), 32'(1));
        chk("free7_idx", 32'(s_aidx), 32'(7));
        repeat (3) step();

`ifdef RDB_AGENT_MC_ERR_CHK_EN
        do_reset();
        set_pld(0, 4'd9, 6'd0, 4'd1);
        drive(2'b01, 1'b1, 1'b0);
        step();
        drive(2'b00, 1'b0, 1'b0);
        step();
        step();
        chk("err_before", 32'(s_err), 32'(0));
        step();
        chk("err_set", 32'(s_err), 32'(1));
        repeat (3) step();
        chk("err_hold", 32'(s_err), 32'(1));
`endif

        // Random traffic with phases of mostly-stalled and mostly-ready upstream.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            set_pld(0, 4'($urandom), 6'($urandom), 4'($urandom));
            set_pld(1, 4'($urandom), 6'($urandom), 4'($urandom));
            drive(2'($urandom), ((k / 50) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 2) == 0);
            step();
        end

        // Reset mid-operation: in-flight requests vanish without a release pulse.
        for (int k = 0; k < 20; k++) begin
            set_pld(0, 4'($urandom), 6'($urandom), 4'($urandom));
            set_pld(1, 4'($urandom), 6'($urandom), 4'($urandom));
            drive(2'b11, $urandom_range(0, 1) == 1, 1'b0);
            step();
        end
        do_reset();
        drive(2'b00, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("post_rst_quiet", 32'({s_men, s_done}), 32'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
